// File: rtl/move_flipper.sv
// move_flipper: places the mover's piece, then walks each capturing direction
// and flips opponent pieces on gameboardRAM until its own piece is reached.
module move_flipper #(
  parameter int RD_LAT = 1,
  parameter int MAX_WALK = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] s_addr_in,
  input  logic       player,
  input  logic [7:0] dir_mask,
  output logic       busy,
  output logic       done_o,
  output logic       err_o,
  output logic [4:0] flip_count,
  output logic [6:0] addr_out,
  output logic [1:0] data_out,
  output logic       wren_o,
  input  logic [1:0] data_in
);
  localparam logic [2:0] IDLE = 3'd0, PLACE = 3'd1, NEXT_DIR = 3'd2, STEP = 3'd3,
                         WAIT = 3'd4, EVAL = 3'd5, WRITE = 3'd6, DONE = 3'd7;
  logic [2:0] state, dir, low;
  logic [6:0] origin, cursor;
  logic       pl;
  logic [7:0] mask, step, wcnt;
  logic [3:0] dr, dc, nr, nc;
  logic [1:0] colour, opp;
  always_comb begin
    colour = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    low = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) low = 3'(i);
    dr = (dir == 3'd0 || dir == 3'd1 || dir == 3'd7) ? 4'hf :
         (dir == 3'd3 || dir == 3'd4 || dir == 3'd5) ? 4'h1 : 4'h0;
    dc = (dir == 3'd1 || dir == 3'd2 || dir == 3'd3) ? 4'h1 :
         (dir == 3'd5 || dir == 3'd6 || dir == 3'd7) ? 4'hf : 4'h0;
    nr = {1'b0, cursor[5:3]} + dr;
    nc = {1'b0, cursor[2:0]} + dc;
  end
  // Outputs decode straight from state so reset removes wren_o immediately.
  assign busy = state != IDLE && state != DONE;
  assign done_o = state == DONE;
  assign wren_o = state == PLACE || state == WRITE;
  assign addr_out = cursor;
  assign data_out = wren_o ? colour : 2'b00;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir <= '0;
      origin <= '0;
      cursor <= '0;
      pl <= 1'b0;
      mask <= '0;
      step <= '0;
      wcnt <= '0;
      flip_count <= '0;
      err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          origin <= s_addr_in;
          cursor <= s_addr_in;
          pl <= player;
          mask <= dir_mask;
          flip_count <= '0;
          err_o <= s_addr_in[6];
          state <= s_addr_in[6] ? DONE : PLACE;
        end
        PLACE: state <= NEXT_DIR;
        NEXT_DIR: if (mask == 8'h00) state <= DONE;
        else begin
          dir <= low;
          mask[low] <= 1'b0;
          cursor <= origin;
          step <= '0;
          state <= STEP;
        end
        // Bit 3 of the 4-bit sums flags both -1 and 8, so edges never wrap.
        STEP: if (nr[3] || nc[3] || step == 8'(MAX_WALK)) begin
          err_o <= 1'b1;
          state <= NEXT_DIR;
        end else begin
          cursor <= {1'b0, nr[2:0], nc[2:0]};
          wcnt <= '0;
          state <= WAIT;
        end
        WAIT: if (wcnt == 8'(RD_LAT - 1)) state <= EVAL;
        else wcnt <= wcnt + 8'd1;
        EVAL: if (data_in == opp) state <= WRITE;
        else begin
          err_o <= err_o | (data_in != colour);
          state <= NEXT_DIR;
        end
        WRITE: begin
          flip_count <= flip_count + 5'd1;
          step <= step + 8'd1;
          state <= STEP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
